// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture sequencer: PDM clock divider, data sampling,
// CIC3 bit feed and clear, settle discard and PCM holding register.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   enable              level, 1 = capture running
//   clk_div             PDM half-period in clk cycles (0 acts as 1)
//   edge_sel            0 = sample at PDM fall, 1 = at PDM rise
//   settle_samples      PCM words discarded after each start
//   pdm_data_in         asynchronous microphone data pin
//   pdm_clk_out         PDM clock to the microphone
//   cic_ce, cic_bit     one-cycle bit strobe and bit to the decimator
//   cic_clear           one-cycle decimator clear at start
//   pcm_in, pcm_in_valid  decimator output word and strobe
//   pcm_data, pcm_ready held word and unread flag (interrupt)
//   read_ack            bus read strobe, clears pcm_ready
//   overrun, overrun_clr  sticky lost-word flag and its clear
//   busy                controller not idle
module pdm_capture_ctrl #(
    parameter int DIV_WIDTH    = 8,
    parameter int SETTLE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [DIV_WIDTH-1:0]    clk_div,
    input  logic                    edge_sel,
    input  logic [SETTLE_WIDTH-1:0] settle_samples,
    input  logic                    pdm_data_in,
    output logic                    pdm_clk_out,
    output logic                    cic_ce,
    output logic                    cic_bit,
    output logic                    cic_clear,
    input  logic [15:0]             pcm_in,
    input  logic                    pcm_in_valid,
    output logic [15:0]             pcm_data,
    output logic                    pcm_ready,
    input  logic                    read_ack,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WARMUP,
        S_RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DIV_WIDTH-1:0]    r_cnt;
    logic [DIV_WIDTH-1:0]    w_hm1;
    logic                    r_pdm_clk;
    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_ce;
    logic                    r_bit;
    logic [SETTLE_WIDTH-1:0] r_settle;
    logic [15:0]             r_pcm;
    logic                    r_ready;
    logic                    r_ovr;
    logic                    w_active;
    logic                    w_wrap;
    logic                    w_event;
    logic                    w_load;
    logic                    w_settle_hit;

    // Divider runs only while a capture is live; dropping enable
    // parks it at count 0 with the PDM clock low.
    assign w_active = (r_state != S_IDLE) && enable;
    assign w_hm1    = (clk_div == '0) ? '0 : clk_div - DIV_WIDTH'(1);
    // >= so a live shrink of clk_div below the count still wraps.
    assign w_wrap   = (r_cnt >= w_hm1);
    // The current clock level tells which edge the wrap produces.
    assign w_event  = w_active && w_wrap && (r_pdm_clk == ~edge_sel);
    assign w_load   = (r_state == S_RUN) && pcm_in_valid;
    assign w_settle_hit = (r_state == S_WARMUP) && pcm_in_valid &&
                          (r_settle == SETTLE_WIDTH'(1));

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:   w_next = S_START;
                S_START:  w_next = (settle_samples == '0) ? S_RUN : S_WARMUP;
                S_WARMUP: w_next = w_settle_hit ? S_RUN : S_WARMUP;
                S_RUN:    w_next = S_RUN;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_pdm_clk <= 1'b0;
        end else if (!w_active) begin
            r_cnt     <= '0;
            r_pdm_clk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt     <= '0;
            r_pdm_clk <= ~r_pdm_clk;
        end else begin
            r_cnt     <= r_cnt + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_ce    <= 1'b0;
            r_bit   <= 1'b0;
        end else begin
            r_sync1 <= pdm_data_in;
            r_sync2 <= r_sync1;
            r_ce    <= w_event;
            if (w_event) begin
                r_bit <= r_sync2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
        end else if (r_state == S_START) begin
            r_settle <= settle_samples;
        end else if ((r_state == S_WARMUP) && pcm_in_valid &&
                     (r_settle != '0)) begin
            r_settle <= r_settle - SETTLE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcm   <= '0;
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_pcm   <= pcm_in;
                r_ready <= 1'b1;
            end else if (read_ack) begin
                r_ready <= 1'b0;
            end
            // A new overrun beats a simultaneous clear.
            if (w_load && r_ready && !read_ack) begin
                r_ovr <= 1'b1;
            end else if (overrun_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign pdm_clk_out = r_pdm_clk;
    assign cic_ce      = r_ce;
    assign cic_bit     = r_bit;
    assign cic_clear   = (r_state == S_START);
    assign pcm_data    = r_pcm;
    assign pcm_ready   = r_ready;
    assign overrun     = r_ovr;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Scoreboard bench for pdm_capture_ctrl: cycle-indexed reference
// built from timing formulas, checked by a separate monitor.
module tb_pdm_capture_ctrl;

    localparam int NC  = 8192;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  clk_div = 8'd1;
    logic        edge_sel = 1'b0;
    logic [7:0]  settle_samples = 8'd0;
    logic        pdm_data_in = 1'b0;
    logic        pdm_clk_out;
    logic        cic_ce;
    logic        cic_bit;
    logic        cic_clear;
    logic [15:0] pcm_in = 16'h0;
    logic        pcm_in_valid = 1'b0;
    logic [15:0] pcm_data;
    logic        pcm_ready;
    logic        read_ack = 1'b0;
    logic        overrun;
    logic        overrun_clr = 1'b0;
    logic        busy;

    pdm_capture_ctrl #(.DIV_WIDTH(8), .SETTLE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clk_div(clk_div),
        .edge_sel(edge_sel), .settle_samples(settle_samples),
        .pdm_data_in(pdm_data_in), .pdm_clk_out(pdm_clk_out),
        .cic_ce(cic_ce), .cic_bit(cic_bit), .cic_clear(cic_clear),
        .pcm_in(pcm_in), .pcm_in_valid(pcm_in_valid),
        .pcm_data(pcm_data), .pcm_ready(pcm_ready), .read_ack(read_ack),
        .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [15:0] v;
    } exp_t;

    exp_t ceq[$];
    exp_t pq[$];

    bit          hist [NC];
    bit          enh  [NC];
    bit          rsth [NC];
    bit          e_pdm[NC];
    bit          e_busy[NC];
    bit          e_clr[NC];
    bit          e_rdy[NC];
    bit          e_ovr[NC];
    logic [15:0] e_data[NC];

    int   T0 = BIG;
    int   seen = 0;
    int   last_c = 0;
    int   cfg_div = 1;
    bit   cfg_es = 1'b0;
    int   cfg_s = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   fin_req = 1'b0;
    bit   fin_done = 1'b0;

    function automatic bit running(int c);
        if (c < 1) return 1'b0;
        return !rsth[c] && !rsth[c-1] && enh[c-1] && (c >= T0);
    endfunction

    function automatic int hval();
        return (cfg_div == 0) ? 1 : cfg_div;
    endfunction

    // One clock cycle of stimulus plus the reference prediction for it.
    task automatic drive(input bit en, input bit pv, input logic [15:0] pval,
                         input bit ack, input bit oclr, input bit rst);
        int  c;
        int  h;
        int  k;
        bit  rc;
        bit  acc;
        bit  set;
        bit  n_rdy;
        bit  n_ovr;
        logic [15:0] n_data;
        @(negedge clk);
        c = cyc;
        if (c >= NC - 2) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", c, NC - 2);
            $fatal(1);
        end
        rst_n          = !rst;
        enable         = en;
        pcm_in_valid   = pv;
        pcm_in         = pval;
        read_ack       = ack;
        overrun_clr    = oclr;
        clk_div        = 8'(cfg_div);
        edge_sel       = cfg_es;
        settle_samples = 8'(cfg_s);
        pdm_data_in    = 1'($urandom_range(0, 1));
        hist[c] = pdm_data_in;
        enh[c]  = en;
        rsth[c] = rst;
        last_c  = c;
        h = hval();
        if (rst) begin
            T0   = BIG;
            seen = 0;
            ceq.delete();
            pq.delete();
            e_rdy[c] = 0; e_ovr[c] = 0; e_data[c] = '0;
            e_rdy[c+1] = 0; e_ovr[c+1] = 0; e_data[c+1] = '0;
            e_pdm[c] = 0; e_busy[c] = 0; e_clr[c] = 0;
            return;
        end
        if (en && (c == 0 || !enh[c-1])) begin
            T0   = c + 1;
            seen = 0;
        end
        rc = running(c);
        e_pdm[c]  = rc ? (((c - T0) / h) % 2 == 1) : 1'b0;
        e_busy[c] = rc;
        e_clr[c]  = rc && (c == T0);
        if (running(c - 1) && enh[c-1]) begin
            k = c - T0;
            if ((k % h == 0) && (((k / h) % 2) == (cfg_es ? 1 : 0)))
                ceq.push_back('{c, {15'h0, hist[c-3]}});
        end
        acc = 1'b0;
        if (rc && c > T0 && pv) begin
            if (seen < cfg_s) seen++;
            else acc = 1'b1;
        end
        n_rdy  = e_rdy[c];
        n_ovr  = e_ovr[c];
        n_data = e_data[c];
        set    = acc && e_rdy[c] && !ack;
        if (acc) begin
            n_rdy  = 1'b1;
            n_data = pval;
            pq.push_back('{c + 1, pval});
        end else if (ack) begin
            n_rdy = 1'b0;
        end
        if (set) n_ovr = 1'b1;
        else if (oclr) n_ovr = 1'b0;
        e_rdy[c+1]  = n_rdy;
        e_ovr[c+1]  = n_ovr;
        e_data[c+1] = n_data;
    endtask

    task automatic quiet(input int n, input bit en);
        for (int i = 0; i < n; i++) drive(en, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rnd_cycle(input bit en);
        bit pv;
        bit ack;
        bit oclr;
        pv   = ($urandom_range(0, 5) == 0);
        ack  = ($urandom_range(0, 3) == 0);
        oclr = ($urandom_range(0, 9) == 0);
        drive(en, pv, 16'($urandom), ack, oclr, 1'b0);
    endtask

    task automatic run(input int div, input bit es, input int s, input int len);
        cfg_div = div;
        cfg_es  = es;
        cfg_s   = s;
        quiet(2, 1'b0);
        for (int i = 0; i < len; i++) rnd_cycle(1'b1);
        for (int i = 0; i < 4; i++) rnd_cycle(1'b0);
    endtask

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            chk("pdm_clk", 16'(pdm_clk_out), 16'(e_pdm[cyc]));
            chk("busy",    16'(busy),        16'(e_busy[cyc]));
            chk("clear",   16'(cic_clear),   16'(e_clr[cyc]));
            chk("ready",   16'(pcm_ready),   16'(e_rdy[cyc]));
            chk("overrun", 16'(overrun),     16'(e_ovr[cyc]));
            chk("pcm_data", pcm_data,        e_data[cyc]);
            if (rsth[cyc]) chk("rst_bit", 16'(cic_bit), 16'h0);
            while (ceq.size() > 0 && ceq[0].c < cyc) begin
                chk("ce_missing", 16'(ceq[0].c), 16'(cyc));
                void'(ceq.pop_front());
            end
            if (cic_ce) begin
                if (ceq.size() == 0 || ceq[0].c != cyc) begin
                    chk("ce_spurious", 16'(cic_ce), 16'h0);
                end else begin
                    chk("cic_bit", 16'(cic_bit), ceq[0].v);
                    void'(ceq.pop_front());
                end
            end
            if (pq.size() > 0 && pq[0].c <= cyc) begin
                chk("word_ready", 16'(pcm_ready), 16'h1);
                chk("word_data", pcm_data, pq[0].v);
                void'(pq.pop_front());
            end
            if (fin_req && !fin_done) begin
                chk("ce_left",   16'(ceq.size()), 16'h0);
                chk("word_left", 16'(pq.size()),  16'h0);
                fin_done = 1'b1;
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        quiet(100, 1'b0);

        run(2, 1'b1, 0, 60);
        run(2, 1'b0, 0, 60);
        run(0, 1'b0, 1, 50);
        run(1, 1'b1, 0, 50);
        run(3, 1'b0, 2, 80);
        run(5, 1'b1, 1, 90);

        cfg_div = 2; cfg_es = 1'b1; cfg_s = 3;
        quiet(2, 1'b0);
        quiet(3, 1'b1);
        drive(1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0); quiet(2, 1'b1);
        drive(1'b1, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b0); quiet(2, 1'b1);
        drive(1'b1, 1'b1, 16'h0033, 1'b0, 1'b0, 1'b0); quiet(2, 1'b1);
        drive(1'b1, 1'b1, 16'h0044, 1'b0, 1'b0, 1'b0); quiet(3, 1'b1);
        drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);    quiet(2, 1'b1);
        drive(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0); quiet(2, 1'b1);
        drive(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0, 1'b0); quiet(2, 1'b1);
        drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);    quiet(2, 1'b1);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);    quiet(2, 1'b1);
        drive(1'b1, 1'b1, 16'haaaa, 1'b0, 1'b0, 1'b0); quiet(2, 1'b1);
        drive(1'b1, 1'b1, 16'hbbbb, 1'b1, 1'b0, 1'b0); quiet(2, 1'b1);
        drive(1'b1, 1'b1, 16'hcccc, 1'b0, 1'b1, 1'b0); quiet(2, 1'b1);

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
            if (e_pdm[last_c]) break;
        end
        quiet(5, 1'b0);
        quiet(20, 1'b1);

        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        quiet(3, 1'b0);

        for (int r = 0; r < 6; r++)
            run($urandom_range(0, 4), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(40, 120));

        quiet(6, 1'b0);
        fin_req = 1'b1;
        quiet(3, 1'b0);
        if (!fin_done) $display("FAIL final_flush cyc=%0d got=0 exp=1", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fin_done ? fails : fails + 1);
        $finish;
    end

endmodule

// File: doc/pdm_capture_ctrl.md
# pdm_capture_ctrl

Sequencing controller for the PDM microphone front end. It runs from the single system clock and does four things:
- generates the microphone's PDM bit clock from a programmable divider;
- synchronises and samples the microphone data line on a selectable edge;
- feeds one bit per PDM period into the CIC3 decimator as a clock-enabled bit stream, and clears the decimator at each start;
- discards the decimator's settling samples, then holds each PCM word for the bus with ready/overrun flags.

## Interface
Parameters:
- DIV_WIDTH, 8, width of the half-period divider setting
- SETTLE_WIDTH, 8, width of the settle (discard) sample count

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = capture running
- clk_div  in  DIV_WIDTH  PDM clock half-period in clk cycles; 0 treated as 1
- edge_sel  in  1  0 = sample at PDM clock falling edge, 1 = rising edge
- settle_samples  in  SETTLE_WIDTH  PCM samples discarded after start
- pdm_data_in  in  1  microphone data pin (asynchronous)
- pdm_clk_out  out  1  PDM clock to microphone
- cic_ce  out  1  one-cycle bit strobe to decimator
- cic_bit  out  1  sampled PDM bit, valid when cic_ce=1
- cic_clear  out  1  one-cycle decimator clear
- pcm_in  in  16  signed PCM from decimator
- pcm_in_valid  in  1  PCM strobe from decimator
- pcm_data  out  16  held PCM word
- pcm_ready  out  1  unread word present; doubles as interrupt
- read_ack  in  1  bus read strobe; clears pcm_ready
- overrun  out  1  sticky: a word was overwritten unread
- overrun_clr  in  1  clears overrun
- busy  out  1  state != IDLE

## Operation
States: IDLE, START, WARMUP, RUN. Encoding is free.
- IDLE: pdm_clk_out=0, divider count=0, cic_ce=0. enable=1 → START.
- START: lasts one cycle with cic_clear=1. Latches settle_samples into the settle counter. Goes to RUN if the count is 0, else WARMUP.
- WARMUP: each pcm_in_valid decrements the settle counter; the word is not stored. The strobe that brings the counter to 0 moves to RUN on the next cycle.
- RUN: each pcm_in_valid is stored as described below.
- enable=0 in any state → IDLE next cycle. pdm_clk_out drives 0 and cic_ce stops. pcm_data, pcm_ready and overrun are retained.

Divider (active in every state except IDLE):
- H = max(clk_div,1). clk_div is read live.
- Count runs 0..H-1. At H-1 the count wraps to 0 and pdm_clk_out toggles.
- The first toggle after START drives pdm_clk_out high.

Data path:
- pdm_data_in passes through a 2-FF synchroniser to give sync_q.
- Edge event: count==H-1 and pdm_clk_out==1 (edge_sel=0), or count==H-1 and pdm_clk_out==0 (edge_sel=1).
- On an edge event, the next cycle has cic_ce=1 and cic_bit=sync_q.

Holding register, on pcm_in_valid in RUN:
- pcm_data←pcm_in and pcm_ready←1.
- If pcm_ready was already 1 and read_ack=0 in the same cycle, overrun←1.

Flag rules:
- read_ack with no new word clears pcm_ready.
- read_ack in the same cycle as pcm_in_valid: new word loaded, pcm_ready stays 1, no overrun.
- overrun_clr clears overrun. If it coincides with a new overrun event, the set wins.

## Timing
- Reset values: pdm_clk_out=0, cic_ce=0, cic_bit=0, cic_clear=0, pcm_data=0, pcm_ready=0, overrun=0, busy=0; state IDLE; all counters 0. Assertion of rst_n=0 mid-capture takes effect immediately.
- enable rises at cycle T:
  - busy=1 and cic_clear=1 at T+1.
  - First pdm_clk_out rise at T+1+H.
- PDM period is 2H clk cycles. cic_ce fires once per period, one cycle after the selected edge.
- Data-pin to cic_bit latency: 2 synchroniser cycles plus the event register.
- pcm_ready rises one cycle after the accepted pcm_in_valid.
- All flags update registered, one cycle after their cause.

## Test plan
- Reset/idle: hold rst_n=0, then release with enable=0 → every output at its reset value and pdm_clk_out static 0 for 100 cycles.
- Divider: enable with clk_div=2 → cic_clear pulse at T+1, then pdm_clk_out high 2 / low 2 with period 4 and cic_ce every 4 cycles. clk_div=0 → period 2, identical to clk_div=1.
- Edge select: pdm_data_in toggles synchronously with pdm_clk_out rise; the pattern 1,0,1,0 is presented on the rising edge. With edge_sel=1, cic_bit reproduces the pattern with cic_ce aligned one cycle after the rise. With edge_sel=0, cic_ce is aligned one cycle after the fall.
- Warm-up: settle_samples=3, pcm_in_valid strobes with values 0x0011, 0x0022, 0x0033, 0x0044 → first three discarded, pcm_data=0x0044, pcm_ready=1.
- Overrun: in RUN, two strobes (0x1234, 0x5678) with no read_ack → pcm_data=0x5678, overrun=1. Then:
  - read_ack clears pcm_ready.
  - read_ack coincident with a strobe → no overrun.
  - overrun_clr coincident with a new overrun → overrun stays 1.
- Disable mid-run: drop enable while pdm_clk_out=1 → next cycle IDLE, busy=0, pdm_clk_out=0, cic_ce silent, and held pcm_data/pcm_ready/overrun retained. Re-enable → new cic_clear pulse.
